dff_bank_arbiter: RTL and testbench

Round-robin arbiter and write sequencer that shares one WIDTH-bit register bank between NREQ requesters. The bank behaves like the team's synchronous-reset master-slave flip-flop cells. The block grants exclusive access, loads the winner's data into the bank, holds ownership while the requester keeps its request, and force-releases owners that exceed a hold limit. It sits between requester logic and the shared storage bank.

---
 rtl/dff_bank_arb_pkg.sv | 14 +
 rtl/dff_bank_arbiter_rr_pick.sv | 28 ++
 rtl/dff_bank_arbiter.sv | 87 ++++++++
 tb/tb_dff_bank_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/dff_bank_arb_pkg.sv
// dff_bank_arb_pkg: state encoding and width helpers shared by the bank arbiter.
package dff_bank_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_e;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

    function automatic int cnt_w(input int h);
        return $clog2(h + 1);
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker; first set req at or after ptr wins.
module rr_pick
    import dff_bank_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   win_o,
    output logic            valid_o
);

    // Scan farthest-first so the closest requester to ptr overwrites last.
    always_comb begin
        int j;
        j     = 0;
        win_o = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= NREQ) j -= NREQ;
            if (req_i[j]) win_o = IW'(j);
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin owner selection and write sequencing for one shared
// register bank, with a hold limit that force-releases long-running owners.
module dff_bank_arbiter
    import dff_bank_arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NREQ     = 4,
    parameter int HOLD_MAX = 15
) (
    input  logic                  clk,
    input  logic                  rs,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      bank_q,
    output logic                  busy,
    output logic                  revoke
);

    localparam int IW = idx_w(NREQ);
    localparam int CW = cnt_w(HOLD_MAX);

    state_e          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d, ptr_q, ptr_d, ptr_nxt, win;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] bank_d;
    logic            revoke_q, revoke_d, win_vld;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .win_o   (win),
        .valid_o (win_vld)
    );

    assign ptr_nxt = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + IW'(1);
    assign gnt     = (state_q == IDLE) ? '0 : NREQ'(1) << owner_q;
    assign busy    = state_q != IDLE;
    assign revoke  = revoke_q;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        bank_d   = bank_q;
        revoke_d = 1'b0;
        case (state_q)
            IDLE: begin
                owner_d = win_vld ? win : owner_q;
                state_d = win_vld ? GRANT : IDLE;
            end
            GRANT: begin
                bank_d  = wdata[owner_q*WIDTH +: WIDTH];
                cnt_d   = '0;
                state_d = req[owner_q] ? HOLD : IDLE;
                ptr_d   = req[owner_q] ? ptr_q : ptr_nxt;
            end
            HOLD: begin
                cnt_d    = cnt_q + CW'(1);
                revoke_d = req[owner_q] && cnt_q == CW'(HOLD_MAX - 1);
                state_d  = (!req[owner_q] || revoke_d) ? IDLE : HOLD;
                ptr_d    = (state_d == IDLE) ? ptr_nxt : ptr_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            bank_q   <= '0;
            revoke_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            bank_q   <= bank_d;
            revoke_q <= revoke_d;
        end
    end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb_dff_bank_arbiter: directed stimulus queues expected grants; a negedge monitor
// pops and checks grant, loaded data, ownership length, revoke and busy.
module tb_dff_bank_arbiter;

    logic        clk = 1'b0;
    logic        rs  = 1'b1;
    logic [3:0]  req = 4'hF;
    logic [31:0] wdata = 32'h3C5AA50F;
    logic [3:0]  gnt;
    logic [7:0]  bank_q;
    logic        busy, revoke;

    typedef struct {
        logic [3:0] g;
        logic [7:0] d;
        int         dur;
        bit         rev;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0, failures = 0, age = 0;
    bit   mon_en = 0, active = 0, bank_due = 0, rev_exp;

    dff_bank_arbiter #(.WIDTH(8), .NREQ(4), .HOLD_MAX(4)) dut (
        .clk    (clk),
        .rs     (rs),
        .req    (req),
        .wdata  (wdata),
        .gnt    (gnt),
        .bank_q (bank_q),
        .busy   (busy),
        .revoke (revoke)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input logic [3:0] g, input logic [7:0] d, input int dur, input bit rev);
        exp_t e;
        e.g = g; e.d = d; e.dur = dur; e.rev = rev;
        sb.push_back(e);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_bank"}, 32'(bank_q), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_revoke"}, 32'(revoke), 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            rev_exp = 1'b0;
            if (bank_due) begin
                check("bank_load", 32'(bank_q), 32'(cur.d));
                bank_due = 1'b0;
            end
            if (active) begin
                if (gnt == cur.g) age++;
                else begin
                    check("hold_len", age, cur.dur);
                    rev_exp = cur.rev;
                    active  = 1'b0;
                    if (gnt != 0) check("gnt_switch", 32'(gnt), 0);
                end
            end else if (gnt != 0) begin
                if (sb.size() == 0) check("unexpected_grant", 32'(gnt), 0);
                else begin
                    cur = sb.pop_front();
                    check("grant", 32'(gnt), 32'(cur.g));
                    active   = 1'b1;
                    age      = 1;
                    bank_due = 1'b1;
                end
            end
            check("revoke", 32'(revoke), 32'(rev_exp));
            check("busy", 32'(busy), 32'(active));
        end
    end

    initial begin
        // Reset held two cycles with all requests up, plus the first free cycle.
        tick();
        @(negedge clk); check_idle_outputs("rst1");
        tick();
        @(negedge clk); check_idle_outputs("rst2");
        tick();
        rs = 1'b0;
        #2 check_idle_outputs("rst_after");
        mon_en = 1'b1;

        // Round robin: each owner keeps req 3 cycles, drops one cycle, re-raises.
        for (int g = 0; g < 5; g++) begin
            expect_grant(4'(1 << (g % 4)), 8'(wdata >> (8 * (g % 4))), 3, 0);
            tick(); tick(); tick();
            req[g % 4] = 1'b0;
            tick();
            req = (g == 4) ? 4'h0 : 4'hF;
        end

        // Single request, ptr then advances to 2.
        expect_grant(4'b0010, 8'hA5, 2, 0);
        req = 4'b0010;
        tick(); tick();
        req = 4'b0000;
        tick();

        // From ptr=2 requester 3 wins over 0 and 1; reset lands mid-HOLD.
        expect_grant(4'b1000, 8'h3C, 2, 0);
        req = 4'b1011;
        tick(); tick();
        rs = 1'b1;
        tick();
        rs  = 1'b0;
        req = 4'b1001;
        @(negedge clk);
        check("rst_hold_gnt", 32'(gnt), 0);
        check("rst_hold_bank", 32'(bank_q), 0);
        check("rst_hold_busy", 32'(busy), 0);

        // Forced release with HOLD_MAX=4: lowest index first, then 3.
        expect_grant(4'b0001, 8'h0F, 5, 1);
        expect_grant(4'b1000, 8'h3C, 5, 1);
        repeat (12) tick();
        req = 4'b0000;

        // Short request: up during IDLE and GRANT only.
        expect_grant(4'b0100, 8'h5A, 1, 0);
        req = 4'b0100;
        tick();
        req = 4'b0000;
        repeat (4) tick();

        @(negedge clk);
        check("sb_empty", sb.size(), 0);
        check("final_idle", 32'(busy), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
